// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC moving-average path.
package adc_pkg;

    localparam int unsigned ADC_DATA_W   = 12;
    localparam int unsigned ADC_MIDSCALE = 2048;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } avg_state_e;

endpackage

// File: rtl/adc_avg_ring.sv
// Circular sample buffer: DEPTH entries, write pointer, combinational read of the oldest entry.
module adc_avg_ring #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0]     entries [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_en) begin
            entries[wr_ptr] <= wr_data;
            wr_ptr          <= wr_ptr + LOG2_DEPTH'(1);
        end
    end

    // The slot about to be overwritten holds the sample leaving the window (0 while filling).
    assign oldest = entries[wr_ptr];

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar moving-average filter for the 12-bit ADC sample stream.
// Define ADC_AVG_DEVIATION_EN to add registered DEV_MAG/DEV_RIGHT outputs.
module adc_moving_average
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_DATA_W,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic              SAMPLE_VALID,
    output logic [DATA_W-1:0] AVG,
    output logic              AVG_VALID,
    output logic              FILLED
`ifdef ADC_AVG_DEVIATION_EN
    ,
    output logic [DATA_W-2:0] DEV_MAG,
    output logic              DEV_RIGHT
`endif
);

    localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;

    logic                  flush;
    logic                  accept;
    logic [DATA_W-1:0]     oldest;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      next_sum;
    logic [SUM_W-1:0]      next_sum_shr;
    logic [DATA_W-1:0]     next_avg;
    logic [LOG2_DEPTH-1:0] fill_cnt;
    avg_state_e            state;

    assign flush  = RESET || CLEAR;
    assign accept = SAMPLE_VALID && !flush;

    adc_avg_ring #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (CLOCK_50),
        .flush   (flush),
        .wr_en   (accept),
        .wr_data (SAMPLE),
        .oldest  (oldest)
    );

    assign next_sum     = sum + SUM_W'(SAMPLE) - SUM_W'(oldest);
    assign next_sum_shr = next_sum >> LOG2_DEPTH;
    assign next_avg     = next_sum_shr[DATA_W-1:0];

`ifdef ADC_AVG_DEVIATION_EN
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

    logic [DATA_W-1:0] dev_full;
    logic [DATA_W-2:0] next_dev_mag;
    logic              next_dev_right;

    always_comb begin
        next_dev_right = next_avg > MID;
        dev_full       = next_dev_right ? (next_avg - MID) : (MID - next_avg);
        // Only AVG == 0 reaches a full midscale distance; clamp it to the largest magnitude.
        next_dev_mag   = dev_full[DATA_W-1] ? '1 : dev_full[DATA_W-2:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (flush) begin
            DEV_MAG   <= '0;
            DEV_RIGHT <= 1'b0;
        end else if (accept) begin
            DEV_MAG   <= next_dev_mag;
            DEV_RIGHT <= next_dev_right;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (flush) begin
            sum       <= '0;
            fill_cnt  <= '0;
            AVG       <= '0;
            AVG_VALID <= 1'b0;
            FILLED    <= 1'b0;
            state     <= FILL;
        end else begin
            AVG_VALID <= 1'b0;
            if (accept) begin
                sum <= next_sum;
                AVG <= next_avg;
                unique case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + LOG2_DEPTH'(1);
                        if (fill_cnt == {LOG2_DEPTH{1'b1}}) begin
                            state     <= RUN;
                            FILLED    <= 1'b1;
                            AVG_VALID <= 1'b1;
                        end
                    end
                    RUN: begin
                        AVG_VALID <= 1'b1;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_moving_average.sv
// Directed bench for adc_moving_average with a queue scoreboard fed by a window model.
module tb_adc_moving_average;
    import adc_pkg::*;

    localparam int DW    = ADC_DATA_W;
    localparam int DEPTH = 8;

    logic          CLOCK_50 = 1'b0;
    logic          RESET = 1'b1;
    logic          CLEAR = 1'b0;
    logic [DW-1:0] SAMPLE = '0;
    logic          SAMPLE_VALID = 1'b0;
    logic [DW-1:0] AVG;
    logic          AVG_VALID;
    logic          FILLED;
`ifdef ADC_AVG_DEVIATION_EN
    logic [DW-2:0] DEV_MAG;
    logic          DEV_RIGHT;
`endif

    adc_moving_average #(
        .DATA_W     (DW),
        .LOG2_DEPTH (3)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .CLEAR        (CLEAR),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .AVG          (AVG),
        .AVG_VALID    (AVG_VALID),
`ifdef ADC_AVG_DEVIATION_EN
        .FILLED       (FILLED),
        .DEV_MAG      (DEV_MAG),
        .DEV_RIGHT    (DEV_RIGHT)
`else
        .FILLED       (FILLED)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int avg;
        int vld;
        int fil;
        int mag;
        int right;
    } exp_t;

    exp_t sb[$];

    int win [DEPTH];
    int m_ptr, m_cnt, m_sum, m_avg, m_mag, m_right;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < DEPTH; i++) win[i] = 0;
        m_ptr = 0; m_cnt = 0; m_sum = 0; m_avg = 0; m_mag = 0; m_right = 0;
    endtask

    // Drive one cycle of inputs, push the model's expectation, then compare after the edge.
    task automatic step(input string tag, input bit rst, input bit clr, input bit vld,
                        input int val);
        exp_t e;
        exp_t got;
        RESET        = rst;
        CLEAR        = clr;
        SAMPLE_VALID = vld;
        SAMPLE       = DW'(val);
        e.vld = 0;
        if (rst || clr) begin
            model_flush();
        end else if (vld) begin
            m_sum = m_sum + val - win[m_ptr];
            win[m_ptr] = val;
            m_ptr = (m_ptr + 1) % DEPTH;
            m_cnt++;
            m_avg = m_sum / DEPTH;
            if (m_avg > ADC_MIDSCALE) begin
                m_mag = m_avg - ADC_MIDSCALE; m_right = 1;
            end else begin
                m_mag = ADC_MIDSCALE - m_avg; m_right = 0;
                if (m_mag > ADC_MIDSCALE - 1) m_mag = ADC_MIDSCALE - 1;
            end
            e.vld = (m_cnt >= DEPTH) ? 1 : 0;
        end
        e.avg = m_avg; e.fil = (m_cnt >= DEPTH) ? 1 : 0; e.mag = m_mag; e.right = m_right;
        sb.push_back(e);
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0; CLEAR = 1'b0; SAMPLE_VALID = 1'b0;
        got = sb.pop_front();
        check($sformatf("%s.avg", tag), 32'(AVG), got.avg);
        check($sformatf("%s.avg_valid", tag), 32'(AVG_VALID), got.vld);
        check($sformatf("%s.filled", tag), 32'(FILLED), got.fil);
`ifdef ADC_AVG_DEVIATION_EN
        check($sformatf("%s.dev_mag", tag), 32'(DEV_MAG), got.mag);
        check($sformatf("%s.dev_right", tag), 32'(DEV_RIGHT), got.right);
`endif
    endtask

    task automatic fill(input string tag, input int val);
        for (int i = 0; i < DEPTH; i++) step(tag, 0, 0, 1, val);
    endtask

    initial begin
        model_flush();
        step("reset", 1, 0, 0, 0);
        step("reset", 1, 0, 0, 0);
        check("reset_avg", 32'(AVG), 0);
        check("reset_filled", 32'(FILLED), 0);

        // Fill with 1000: valid only on the 8th accepting edge.
        for (int i = 0; i < DEPTH - 1; i++) step("fill1000", 0, 0, 1, 1000);
        check("fill1000_pre_valid", 32'(AVG_VALID), 0);
        step("fill1000", 0, 0, 1, 1000);
        check("fill1000_avg", 32'(AVG), 1000);
        check("fill1000_valid", 32'(AVG_VALID), 1);
        check("fill1000_filled", 32'(FILLED), 1);
`ifdef ADC_AVG_DEVIATION_EN
        check("dev1000_mag", 32'(DEV_MAG), 1048);
        check("dev1000_right", 32'(DEV_RIGHT), 0);
`endif
        step("idle", 0, 0, 0, 0);
        check("hold_avg", 32'(AVG), 1000);

        // Truncating divide.
        step("reset", 1, 0, 0, 0);
        fill("zeros", 0);
        step("max", 0, 0, 1, 4095);
        check("trunc_avg", 32'(AVG), 511);

        // Wrap-around: oldest 0 replaced by 800.
        step("reset", 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step("ramp", 0, 0, 1, i * 100);
        step("wrap", 0, 0, 1, 800);
        check("wrap_avg", 32'(AVG), 450);

        // CLEAR wins over a same-cycle sample.
        step("clear", 0, 1, 1, 4000);
        check("clear_filled", 32'(FILLED), 0);
        check("clear_avg", 32'(AVG), 0);
        check("clear_valid", 32'(AVG_VALID), 0);
        fill("fill2000", 2000);
        check("fill2000_avg", 32'(AVG), 2000);

        // Sparse strobes: AVG holds and AVG_VALID pulses once per accepted sample.
        step("reset", 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step("sparse", 0, 0, 1, int'($urandom_range(0, 4095)));
            for (int j = 0; j < 4; j++) step("sparse_idle", 0, 0, 0, 0);
        end

        // Full-rate random stream across several wraps.
        for (int k = 0; k < 24; k++) step("burst", 0, 0, 1, int'($urandom_range(0, 4095)));

        // Reset mid-operation discards history.
        step("midreset", 1, 0, 1, 3333);
        check("midreset_avg", 32'(AVG), 0);
        check("midreset_valid", 32'(AVG_VALID), 0);

        fill("fill3000", 3000);
        check("fill3000_avg", 32'(AVG), 3000);
`ifdef ADC_AVG_DEVIATION_EN
        check("dev3000_mag", 32'(DEV_MAG), 952);
        check("dev3000_right", 32'(DEV_RIGHT), 1);
`endif
        step("reset", 1, 0, 0, 0);
        fill("fill2048", 2048);
        check("fill2048_avg", 32'(AVG), 2048);
`ifdef ADC_AVG_DEVIATION_EN
        check("dev2048_mag", 32'(DEV_MAG), 0);
        check("dev2048_right", 32'(DEV_RIGHT), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_moving_average.md
Name: adc_moving_average

Overview:
- Boxcar moving-average filter between the SPI ADC controller (12-bit channel sample) and the LED/deviation mapping logic.
- Accepts one 12-bit sample per SAMPLE_VALID pulse and keeps the last 2^LOG2_DEPTH samples in a circular buffer.
- Emits the running mean with a valid strobe, so the downstream LED logic stops flickering on ADC noise.

Parameters:
- DATA_W, 12, sample and average width in bits.
- LOG2_DEPTH, 3, log2 of window length; DEPTH = 2^LOG2_DEPTH = 8 samples; legal range 1..6.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CLEAR  input  1  synchronous flush of window, same effect as RESET on filter state.
- SAMPLE  input  DATA_W  raw ADC sample, unsigned.
- SAMPLE_VALID  input  1  single-cycle strobe; SAMPLE is accepted on the same edge.
- AVG  output  DATA_W  registered window mean, unsigned.
- AVG_VALID  output  1  single-cycle strobe; AVG was updated on this edge.
- FILLED  output  1  high once DEPTH samples have been accepted since the last reset or clear.

Behaviour:
- Reset (RESET=1 at an edge):
  - Buffer entries, SUM, write pointer, fill count, AVG, AVG_VALID and FILLED all go to 0.
  - State goes to FILL.
  - Reset mid-operation discards all history; no AVG_VALID fires on the reset edge.
- CLEAR has the same effect as reset, with RESET taking priority.
  - CLEAR and SAMPLE_VALID in the same cycle: CLEAR wins and the sample is dropped.
- Storage:
  - Circular buffer of DEPTH x DATA_W registers.
  - Write pointer is LOG2_DEPTH bits and wraps naturally from DEPTH-1 to 0.
  - Running SUM is DATA_W+LOG2_DEPTH bits wide; it never overflows.
- On an accepted sample:
  - next_sum = SUM + SAMPLE - buf[wr_ptr], where buf[wr_ptr] is the oldest entry (0 during FILL).
  - buf[wr_ptr] <= SAMPLE; wr_ptr increments; SUM <= next_sum.
  - AVG <= next_sum >> LOG2_DEPTH, i.e. truncating divide, all on the same edge.
  - Latency is 1 cycle: the AVG/AVG_VALID edge is the edge that accepts the sample.
  - Back-to-back SAMPLE_VALID on every cycle is supported at full rate.
- FSM:
  - FILL: the fill counter counts accepted samples. AVG still updates (it reads as the sum divided by DEPTH) but AVG_VALID is held at 0. On acceptance of sample number DEPTH, go to RUN and assert FILLED and AVG_VALID on that same edge.
  - RUN: AVG_VALID = 1 on the edge of every accepted sample, 0 otherwise. FILLED stays at 1. Leave RUN only via RESET or CLEAR.
- AVG holds its value between samples.
- SAMPLE is ignored when SAMPLE_VALID=0.

Optional Feature:
- Macro ADC_AVG_DEVIATION_EN.
- When defined, two extra outputs are added:
  - DEV_MAG, DATA_W-1 bits: |AVG - 2^(DATA_W-1)|, saturated to 2^(DATA_W-1)-1.
  - DEV_RIGHT, 1 bit: 1 when AVG > midscale, 0 otherwise.
  - Both are registered on the same edge as AVG (same latency) and reset to 0.
  - At exact midscale: DEV_MAG=0, DEV_RIGHT=0.
- When undefined, these ports and their logic are absent; the downstream stage derives deviation itself.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_DATA_W=12.
  - ADC_MIDSCALE=2048.
  - The FSM state typedef (FILL, RUN).
- Sub-module adc_avg_ring is natural: DEPTH-entry circular buffer with write pointer and oldest-entry read. The top module keeps SUM, FSM and outputs.

Test Plan:
- Reset, then 8 samples of 1000 back-to-back: AVG_VALID stays 0 for the first 7 edges; on the 8th edge AVG=1000, AVG_VALID=1, FILLED=1.
- Fill with 8 samples of 0, then one sample of 4095: AVG=511, i.e. 4095/8 truncated.
- Wrap-around: fill with 0..7 ×100, then feed 800: window is 100..800, so AVG = 3600/8 = 450.
- CLEAR asserted together with SAMPLE_VALID (SAMPLE=4000) while in RUN: FILLED=0, AVG=0, AVG_VALID=0, sample dropped. The next 8 samples of 2000 give AVG=2000 on the 8th edge.
- Sparse input (SAMPLE_VALID every 5th cycle): AVG holds between strobes, and AVG_VALID pulses exactly once per strobe on the accepting edge.
- With ADC_AVG_DEVIATION_EN, window full of 1000: DEV_MAG=1048, DEV_RIGHT=0. Window full of 3000: DEV_MAG=952, DEV_RIGHT=1. Window full of 2048: DEV_MAG=0, DEV_RIGHT=0.
